regfile_dump_reader: RTL and testbench



---
 rtl/regfile_dump_reader.sv | 140 ++++++++++++++
 tb/tb_regfile_dump_reader.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Walks register file read port 1 over every register and streams each word out little-endian as bytes.
// Optional trailing XOR checksum byte is enabled by defining REGDUMP_CHECKSUM_EN.
module regfile_dump_reader #(
  parameter int N_BITS     = 32,
  parameter int N_BITS_REG = 5,
  parameter int N_REGS     = 32,
  parameter int BYTE_BITS  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  output logic [N_BITS_REG-1:0] o_read_reg,
  output logic                  o_rf_valid,
  input  logic [N_BITS-1:0]     i_read_data,
  output logic [BYTE_BITS-1:0]  o_byte,
  output logic                  o_byte_valid,
  input  logic                  i_byte_ready,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int NBYTES = N_BITS / BYTE_BITS;
  localparam int KW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [N_BITS_REG-1:0] LAST_IDX = N_BITS_REG'(N_REGS - 1);
  localparam logic [KW-1:0]         LAST_K   = KW'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_SEND, S_NEXT, S_DONE, S_CSUM
  } state_t;

  state_t                state_q, state_d;
  logic [N_BITS_REG-1:0] idx_q, idx_d;
  logic [KW-1:0]         cnt_q, cnt_d;
  logic [N_BITS-1:0]     word_q, word_d;
  logic [BYTE_BITS-1:0]  cur_byte;
  logic                  xfer;
`ifdef REGDUMP_CHECKSUM_EN
  logic [BYTE_BITS-1:0]  csum_q, csum_d;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign cur_byte = word_q[cnt_q*BYTE_BITS +: BYTE_BITS];
  // Outputs decode state only, so ready never reaches valid combinationally.
  assign xfer     = o_byte_valid && i_byte_ready;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
`ifdef REGDUMP_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    o_read_reg   = idx_q;
    o_rf_valid   = 1'b0;
    o_byte       = '0;
    o_byte_valid = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          idx_d   = '0;
          cnt_d   = '0;
`ifdef REGDUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = S_READ;
        end
      end
      S_READ: begin
        o_busy     = 1'b1;
        o_rf_valid = 1'b1;
        state_d    = S_LATCH;
      end
      S_LATCH: begin
        o_busy  = 1'b1;
        word_d  = i_read_data;
        cnt_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        o_busy       = 1'b1;
        o_byte       = cur_byte;
        o_byte_valid = 1'b1;
        if (xfer) begin
`ifdef REGDUMP_CHECKSUM_EN
          csum_d = csum_q ^ cur_byte;
`endif
          if (cnt_q == LAST_K) state_d = S_NEXT;
          else                 cnt_d   = cnt_q + 1'b1;
        end
      end
      S_NEXT: begin
        o_busy = 1'b1;
        if (idx_q == LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_READ;
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      S_CSUM: begin
        o_busy       = 1'b1;
        o_byte       = csum_q;
        o_byte_valid = 1'b1;
        if (xfer) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench: register-file model plus a byte-queue reference built from register contents.
module tb_regfile_dump_reader;
  localparam int N_BITS = 32, N_BITS_REG = 5, N_REGS = 32, BYTE_BITS = 8;
  localparam int NB = N_BITS / BYTE_BITS;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int CS = 1;
  localparam logic [7:0] LAST5 = 8'h08;
`else
  localparam int CS = 0;
  localparam logic [7:0] LAST5 = 8'h12;
`endif
  localparam int EXP_DONE = N_REGS * (3 + NB) + 1 + CS;

  logic                  i_clk = 1'b0;
  logic                  i_reset, i_start, i_byte_ready;
  logic [N_BITS_REG-1:0] o_read_reg;
  logic                  o_rf_valid, o_byte_valid, o_busy, o_done;
  logic [N_BITS-1:0]     i_read_data;
  logic [BYTE_BITS-1:0]  o_byte;

  logic [31:0] regs [N_REGS];
  logic [31:0] rf_rdata = '0;
  logic [7:0]  expq [$];
  int checks = 0, errors = 0;
  logic [7:0] last_b;

  regfile_dump_reader #(.N_BITS(N_BITS), .N_BITS_REG(N_BITS_REG), .N_REGS(N_REGS),
                        .BYTE_BITS(BYTE_BITS)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .o_read_reg(o_read_reg), .o_rf_valid(o_rf_valid), .i_read_data(i_read_data),
    .o_byte(o_byte), .o_byte_valid(o_byte_valid), .i_byte_ready(i_byte_ready),
    .o_busy(o_busy), .o_done(o_done));

  always #5 i_clk = ~i_clk;

  // Register file read port 1: registered data, valid one cycle after the enable.
  always @(posedge i_clk) if (o_rf_valid) rf_rdata <= regs[o_read_reg];
  assign i_read_data = rf_rdata;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic build_exp();
    logic [7:0] cs = '0;
    expq.delete();
    for (int r = 0; r < N_REGS; r++)
      for (int k = 0; k < NB; k++) begin
        expq.push_back(8'((regs[r] >> (8 * k)) & 32'hFF));
        cs ^= 8'((regs[r] >> (8 * k)) & 32'hFF);
      end
    if (CS != 0) expq.push_back(cs);
  endtask

  // mode 0: ready high, 1: random ready, 2: stall 5 cycles per byte
  task automatic run_dump(input int mode, input int restart_cyc, input int abort_at,
                          input bit chk_time, output logic [7:0] lastb);
    int cyc = 0, bpos = 0, rd_idx = 0, stall = 0, done_cnt = 0, done_cyc = 0;
    bit rdy, aborted = 0;
    lastb = '0;
    build_exp();
    @(negedge i_clk);
    i_start = 1'b1;
    while (cyc < 3000) begin
      @(negedge i_clk);
      cyc++;
      i_start = (cyc == restart_cyc);
      chk("busy", {31'd0, o_busy}, {31'd0, (done_cnt == 0 && !o_done)});
      if (o_rf_valid) begin
        chk("rd_addr", {27'd0, o_read_reg}, rd_idx);
        rd_idx++;
      end
      rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 0);
      if (o_byte_valid) begin
        if (bpos < expq.size()) chk("byte", {24'd0, o_byte}, {24'd0, expq[bpos]});
        else chk("extra_byte", bpos, expq.size());
        if (abort_at >= 0 && bpos == abort_at) begin
          i_reset = 1'b1;
          @(negedge i_clk);
          chk("rst_abort_out", {o_read_reg, o_rf_valid, o_byte, o_byte_valid, o_busy, o_done}, 0);
          i_reset = 1'b0;
          aborted = 1;
          break;
        end
        if (mode == 2) begin
          if (stall < 5) begin rdy = 0; stall++; end
          else begin rdy = 1; stall = 0; end
        end
        if (rdy) begin lastb = o_byte; bpos++; end
      end
      i_byte_ready = rdy;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("bytes_at_done", bpos, expq.size());
        chk("reads_at_done", rd_idx, N_REGS);
      end
      if (done_cnt > 0 && cyc >= done_cyc + 4) break;
    end
    i_start = 1'b0;
    if (!aborted) begin
      chk("done_count", done_cnt, 1);
      chk("bytes_total", bpos, expq.size());
      if (chk_time) chk("done_cycle", done_cyc, EXP_DONE);
    end
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_byte_ready = 1'b0;
    for (int r = 0; r < N_REGS; r++) regs[r] = $urandom;
    repeat (2) @(negedge i_clk);
    chk("reset_out", {o_read_reg, o_rf_valid, o_byte, o_byte_valid, o_busy, o_done}, 0);
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);

    // Incrementing pattern, ready tied high, exact duration
    for (int r = 0; r < N_REGS; r++) regs[r] = 32'h0000_0100 * r + r;
    run_dump(0, -1, -1, 1'b1, last_b);

    // Long stalls on every byte with a recognisable word in register 1
    for (int r = 0; r < N_REGS; r++) regs[r] = $urandom;
    regs[1] = 32'hDEADBEEF;
    run_dump(2, -1, -1, 1'b0, last_b);

    // Second start mid-dump must be ignored
    for (int r = 0; r < N_REGS; r++) regs[r] = $urandom;
    run_dump(0, 10, -1, 1'b1, last_b);

    // Reset while sending register 7 byte 2, then a clean dump from register 0
    run_dump(0, -1, 7 * NB + 2, 1'b0, last_b);
    repeat (2) @(negedge i_clk);
    run_dump(1, -1, -1, 1'b0, last_b);

    // Random ready with several random register images
    for (int t = 0; t < 3; t++) begin
      for (int r = 0; r < N_REGS; r++) regs[r] = $urandom;
      run_dump(1, -1, -1, 1'b0, last_b);
    end

    // Sparse image: last byte is the checksum (or register 31's top byte)
    for (int r = 0; r < N_REGS; r++) regs[r] = '0;
    regs[31] = 32'h1234_5678;
    run_dump(1, -1, -1, 1'b0, last_b);
    chk("last_byte", {24'd0, last_b}, {24'd0, LAST5});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
